// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Two-master arbiter for the external data memory port, with watchdog.
// Revision : 1.0
// ============================================================================
module mem_arbiter #(
    parameter int FIXED_PRIO     = 0,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        m0_req_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_be_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_wd_i,
    output logic [31:0] m0_rd_o,
    output logic        m0_ready_o,
    input  logic        m1_req_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_be_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_wd_i,
    output logic [31:0] m1_rd_o,
    output logic        m1_ready_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    input  logic        mem_ready_i,
    output logic [1:0]  grant_o,
    output logic        timeout_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2,
        ABORT  = 2'd3
    } state_t;

    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);
    localparam logic        TIMEOUT_EN    = (TIMEOUT_CYCLES != 0);
    localparam logic        ROUND_ROBIN   = (FIXED_PRIO == 0);

    state_t      state;
    logic        last;
    logic [15:0] wait_cnt;
    logic [15:0] wait_cnt_inc;
    logic        in_grant0;
    logic        in_grant1;
    logic        in_abort;

    assign wait_cnt_inc = wait_cnt + 16'd1;

    // 'last' is updated on entry to ABORT so that, while aborting, it already
    // names the port that must receive the error completion.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            last     <= 1'b1;
            wait_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    wait_cnt <= '0;
                    if (m0_req_i && m1_req_i) begin
                        state <= (!ROUND_ROBIN || last) ? GRANT0 : GRANT1;
                    end else if (m0_req_i) begin
                        state <= GRANT0;
                    end else if (m1_req_i) begin
                        state <= GRANT1;
                    end
                end
                GRANT0: begin
                    if (mem_ready_i) begin
                        last     <= 1'b0;
                        wait_cnt <= '0;
                        state    <= (ROUND_ROBIN && m1_req_i) ? GRANT1 : IDLE;
                    end else begin
                        wait_cnt <= wait_cnt_inc;
                        if (TIMEOUT_EN && (wait_cnt_inc == TIMEOUT_LIMIT)) begin
                            last  <= 1'b0;
                            state <= ABORT;
                        end
                    end
                end
                GRANT1: begin
                    if (mem_ready_i) begin
                        last     <= 1'b1;
                        wait_cnt <= '0;
                        state    <= (ROUND_ROBIN && m0_req_i) ? GRANT0 : IDLE;
                    end else begin
                        wait_cnt <= wait_cnt_inc;
                        if (TIMEOUT_EN && (wait_cnt_inc == TIMEOUT_LIMIT)) begin
                            last  <= 1'b1;
                            state <= ABORT;
                        end
                    end
                end
                ABORT: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign in_grant0 = (state == GRANT0);
    assign in_grant1 = (state == GRANT1);
    assign in_abort  = (state == ABORT);

    always_comb begin
        mem_we_o   = 1'b0;
        mem_be_o   = '0;
        mem_addr_o = '0;
        mem_wd_o   = '0;
        if (in_grant0) begin
            mem_we_o   = m0_we_i;
            mem_be_o   = m0_be_i;
            mem_addr_o = m0_addr_i;
            mem_wd_o   = m0_wd_i;
        end else if (in_grant1) begin
            mem_we_o   = m1_we_i;
            mem_be_o   = m1_be_i;
            mem_addr_o = m1_addr_i;
            mem_wd_o   = m1_wd_i;
        end
    end

    assign mem_req_o  = in_grant0 | in_grant1;
    assign grant_o    = {in_grant1, in_grant0};
    assign timeout_o  = in_abort;
    assign m0_ready_o = (in_grant0 & mem_ready_i) | (in_abort & ~last);
    assign m1_ready_o = (in_grant1 & mem_ready_i) | (in_abort & last);
    assign m0_rd_o    = in_grant0 ? mem_rd_i : '0;
    assign m1_rd_o    = in_grant1 ? mem_rd_i : '0;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Directed and random checks of mem_arbiter against a transaction model.
// Revision : 1.0
// ============================================================================
module tb_mem_arbiter;

    // Instance 0: round-robin, watchdog 4.  Instance 1: fixed priority, no watchdog.
    localparam int FP0 = 0;
    localparam int TO0 = 4;
    localparam int FP1 = 1;
    localparam int TO1 = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic        m0_req[2], m1_req[2], m0_we[2], m1_we[2], mem_ready[2];
    logic [3:0]  m0_be[2], m1_be[2];
    logic [31:0] m0_addr[2], m1_addr[2], m0_wd[2], m1_wd[2], mem_rd[2];

    logic        m0_ready[2], m1_ready[2], mem_req[2], mem_we[2], timeout[2];
    logic [3:0]  mem_be[2];
    logic [1:0]  grant[2];
    logic [31:0] m0_rd[2], m1_rd[2], mem_addr[2], mem_wd[2];

    mem_arbiter #(.FIXED_PRIO(FP0), .TIMEOUT_CYCLES(TO0)) u_rr (
        .clk_i(clk), .rst_i(rst),
        .m0_req_i(m0_req[0]), .m0_we_i(m0_we[0]), .m0_be_i(m0_be[0]),
        .m0_addr_i(m0_addr[0]), .m0_wd_i(m0_wd[0]), .m0_rd_o(m0_rd[0]), .m0_ready_o(m0_ready[0]),
        .m1_req_i(m1_req[0]), .m1_we_i(m1_we[0]), .m1_be_i(m1_be[0]),
        .m1_addr_i(m1_addr[0]), .m1_wd_i(m1_wd[0]), .m1_rd_o(m1_rd[0]), .m1_ready_o(m1_ready[0]),
        .mem_req_o(mem_req[0]), .mem_we_o(mem_we[0]), .mem_be_o(mem_be[0]),
        .mem_addr_o(mem_addr[0]), .mem_wd_o(mem_wd[0]), .mem_rd_i(mem_rd[0]),
        .mem_ready_i(mem_ready[0]), .grant_o(grant[0]), .timeout_o(timeout[0])
    );

    mem_arbiter #(.FIXED_PRIO(FP1), .TIMEOUT_CYCLES(TO1)) u_fp (
        .clk_i(clk), .rst_i(rst),
        .m0_req_i(m0_req[1]), .m0_we_i(m0_we[1]), .m0_be_i(m0_be[1]),
        .m0_addr_i(m0_addr[1]), .m0_wd_i(m0_wd[1]), .m0_rd_o(m0_rd[1]), .m0_ready_o(m0_ready[1]),
        .m1_req_i(m1_req[1]), .m1_we_i(m1_we[1]), .m1_be_i(m1_be[1]),
        .m1_addr_i(m1_addr[1]), .m1_wd_i(m1_wd[1]), .m1_rd_o(m1_rd[1]), .m1_ready_o(m1_ready[1]),
        .mem_req_o(mem_req[1]), .mem_we_o(mem_we[1]), .mem_be_o(mem_be[1]),
        .mem_addr_o(mem_addr[1]), .mem_wd_o(mem_wd[1]), .mem_rd_i(mem_rd[1]),
        .mem_ready_i(mem_ready[1]), .grant_o(grant[1]), .timeout_o(timeout[1])
    );

    int errors = 0;
    int checks = 0;

    // Transaction-level model: who owns the memory, who is being aborted,
    // who was served last and how long the current owner has stalled.
    int   owner[2];
    logic aborting[2];
    int   ab_port[2];
    int   last_port[2];
    int   stall[2];
    logic rdy0[2], rdy1[2];

    function automatic logic fp(int d);
        return (d == 0) ? (FP0 != 0) : (FP1 != 0);
    endfunction

    function automatic int tmo(int d);
        return (d == 0) ? TO0 : TO1;
    endfunction

    task automatic model_reset(int d);
        owner[d]     = -1;
        aborting[d]  = 1'b0;
        ab_port[d]   = 0;
        last_port[d] = 1;
        stall[d]     = 0;
    endtask

    function automatic logic pred_ready(int d, int n);
        if (aborting[d]) return (ab_port[d] == n);
        return (owner[d] == n) && mem_ready[d];
    endfunction

    function automatic logic [138:0] predict(int d);
        logic [1:0]  g  = '0;
        logic        rq = 1'b0;
        logic        we = 1'b0;
        logic [3:0]  be = '0;
        logic [31:0] a  = '0;
        logic [31:0] wd = '0;
        logic [31:0] r0 = '0;
        logic [31:0] r1 = '0;
        if (owner[d] == 0) begin
            g = 2'b01; rq = 1'b1; we = m0_we[d]; be = m0_be[d]; a = m0_addr[d]; wd = m0_wd[d];
            r0 = mem_rd[d];
        end else if (owner[d] == 1) begin
            g = 2'b10; rq = 1'b1; we = m1_we[d]; be = m1_be[d]; a = m1_addr[d]; wd = m1_wd[d];
            r1 = mem_rd[d];
        end
        return {g, rq, we, be, a, wd, pred_ready(d, 0), pred_ready(d, 1), r0, r1, aborting[d]};
    endfunction

    function automatic logic [138:0] observe(int d);
        return {grant[d], mem_req[d], mem_we[d], mem_be[d], mem_addr[d], mem_wd[d],
                m0_ready[d], m1_ready[d], m0_rd[d], m1_rd[d], timeout[d]};
    endfunction

    task automatic model_step(int d);
        logic r0;
        logic r1;
        logic other;
        int   n;
        r0 = m0_req[d];
        r1 = m1_req[d];
        if (aborting[d]) begin
            aborting[d]  = 1'b0;
            last_port[d] = ab_port[d];
        end else if (owner[d] < 0) begin
            stall[d] = 0;
            if (r0 && r1)  owner[d] = (fp(d) || last_port[d] == 1) ? 0 : 1;
            else if (r0)   owner[d] = 0;
            else if (r1)   owner[d] = 1;
        end else if (mem_ready[d]) begin
            n            = owner[d];
            other        = (n == 0) ? r1 : r0;
            last_port[d] = n;
            stall[d]     = 0;
            owner[d]     = (!fp(d) && other) ? 1 - n : -1;
        end else begin
            stall[d] = stall[d] + 1;
            if (tmo(d) != 0 && stall[d] == tmo(d)) begin
                aborting[d] = 1'b1;
                ab_port[d]  = owner[d];
                owner[d]    = -1;
            end
        end
    endtask

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock: compare every output of both instances on the falling edge,
    // then advance the model on the rising edge; returns 1 time unit later.
    task automatic tick();
        logic [138:0] exp;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            if (rst) model_reset(d);
            exp     = predict(d);
            rdy0[d] = pred_ready(d, 0);
            rdy1[d] = pred_ready(d, 1);
            checks++;
            assert (observe(d) === exp) else begin
                errors++;
                $error("FAIL outputs dut=%0d t=%0t got=%h exp=%h", d, $time, observe(d), exp);
            end
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (rst) model_reset(d);
            else     model_step(d);
        end
        #1;
    endtask

    int n0;
    int n1;

    initial begin
        for (int d = 0; d < 2; d++) begin
            m0_req[d] = 0; m1_req[d] = 0; m0_we[d] = 0; m1_we[d] = 0;
            m0_be[d] = 0; m1_be[d] = 0; m0_addr[d] = 0; m1_addr[d] = 0;
            m0_wd[d] = 0; m1_wd[d] = 0; mem_rd[d] = 0; mem_ready[d] = 0;
            rdy0[d] = 0; rdy1[d] = 0;
            model_reset(d);
        end
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("reset_grant", 32'(grant[0]), 32'd0);
        chk("reset_req", 32'(mem_req[0]), 32'd0);
        chk("reset_timeout", 32'(timeout[1]), 32'd0);
        tick();
        rst = 1'b0;

        // Round-robin contention from reset: port 0 first, then port 1 with no bubble.
        m0_req[0] = 1; m0_addr[0] = 32'h100;
        m1_req[0] = 1; m1_addr[0] = 32'h200;
        tick();
        chk("rr_first_grant", 32'(grant[0]), 32'h1);
        mem_ready[0] = 1; mem_rd[0] = 32'hDEAD_BEEF;
        #1;
        chk("rr_m0_rd", m0_rd[0], 32'hDEAD_BEEF);
        chk("rr_m1_idle_ready", 32'(m1_ready[0]), 32'd0);
        tick();
        m0_req[0] = 0;
        chk("rr_second_grant", 32'(grant[0]), 32'h2);
        mem_rd[0] = 32'h1234_5678;
        #1;
        chk("rr_m1_ready", 32'(m1_ready[0]), 32'd1);
        chk("rr_m1_rd", m1_rd[0], 32'h1234_5678);
        chk("rr_m1_addr", mem_addr[0], 32'h200);
        tick();
        m1_req[0] = 0; mem_ready[0] = 0;
        chk("rr_back_idle", 32'(grant[0]), 32'd0);
        tick();

        // Watchdog: four stalled grant cycles, one abort cycle, late ready ignored.
        m1_req[0] = 1; m1_addr[0] = 32'h300; mem_rd[0] = 32'hCAFE_0001;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("to_grant_held", 32'(grant[0]), 32'h2);
            tick();
        end
        chk("to_abort_ready", 32'(m1_ready[0]), 32'd1);
        chk("to_abort_rd", m1_rd[0], 32'd0);
        chk("to_abort_pulse", 32'(timeout[0]), 32'd1);
        chk("to_abort_noreq", 32'(mem_req[0]), 32'd0);
        tick();
        m1_req[0] = 0; mem_ready[0] = 1;
        #1;
        chk("to_pulse_once", 32'(timeout[0]), 32'd0);
        chk("to_late_ready", 32'(m1_ready[0]), 32'd0);
        tick();
        chk("to_idle", 32'(grant[0]), 32'd0);
        mem_ready[0] = 0;
        tick();

        // Single master write, memory ready in the second grant cycle.
        m0_req[0] = 1; m0_we[0] = 1; m0_be[0] = 4'hF; m0_addr[0] = 32'h10; m0_wd[0] = 32'hA5A5_0001;
        mem_rd[0] = 32'h0BAD_0BAD;
        #1;
        chk("single_idle_req", 32'(mem_req[0]), 32'd0);
        tick();
        chk("single_req1", 32'(mem_req[0]), 32'd1);
        chk("single_wd", mem_wd[0], 32'hA5A5_0001);
        chk("single_not_ready", 32'(m0_ready[0]), 32'd0);
        tick();
        mem_ready[0] = 1;
        #1;
        chk("single_req2", 32'(mem_req[0]), 32'd1);
        chk("single_ready", 32'(m0_ready[0]), 32'd1);
        chk("single_m1_rd", m1_rd[0], 32'd0);
        tick();
        m0_req[0] = 0; m0_we[0] = 0; mem_ready[0] = 0;
        chk("single_idle", 32'(mem_req[0]), 32'd0);
        tick();

        // Asynchronous reset during a grant; afterwards port 0 wins again.
        m0_req[0] = 1; m0_addr[0] = 32'h44;
        tick();
        chk("rst_pre_grant", 32'(grant[0]), 32'h1);
        mem_ready[0] = 1;
        #2 rst = 1'b1;
        #1;
        model_reset(0);
        model_reset(1);
        chk("rst_async_req", 32'(mem_req[0]), 32'd0);
        chk("rst_async_grant", 32'(grant[0]), 32'd0);
        chk("rst_async_ready", 32'(m0_ready[0]), 32'd0);
        chk("rst_async_addr", mem_addr[0], 32'd0);
        tick();
        rst = 1'b0; mem_ready[0] = 0;
        m1_req[0] = 1;
        tick();
        chk("rst_port0_first", 32'(grant[0]), 32'h1);
        mem_ready[0] = 1;
        tick();
        m0_req[0] = 0;
        tick();
        m1_req[0] = 0; mem_ready[0] = 0;
        tick();

        // Fixed priority: three back-to-back transactions per port.
        n0 = 0; n1 = 0;
        m0_req[1] = 1; m0_addr[1] = 32'h1000;
        m1_req[1] = 1; m1_addr[1] = 32'h2000;
        for (int cyc = 0; cyc < 60 && (n0 < 3 || n1 < 3); cyc++) begin
            mem_ready[1] = (cyc % 2 == 1);
            mem_rd[1]    = $urandom;
            tick();
            if (rdy0[1]) begin
                n0++;
                if (n0 == 3) m0_req[1] = 0; else m0_addr[1] = m0_addr[1] + 4;
            end
            if (rdy1[1]) begin
                n1++;
                if (n1 == 3) m1_req[1] = 0; else m1_addr[1] = m1_addr[1] + 4;
            end
            chk("fp_order", 32'(grant[1][1] && (n0 < 3)), 32'd0);
        end
        chk("fp_m0_done", 32'(n0), 32'd3);
        chk("fp_m1_done", 32'(n1), 32'd3);
        m0_req[1] = 0; m1_req[1] = 0; mem_ready[1] = 0;
        tick();

        // Watchdog disabled: a 1000-cycle stall completes normally.
        m1_req[1] = 1; m1_addr[1] = 32'h3000; mem_rd[1] = 32'h5555_AAAA;
        tick();
        for (int i = 0; i < 1000; i++) tick();
        chk("nto_still_granted", 32'(grant[1]), 32'h2);
        mem_ready[1] = 1;
        #1;
        chk("nto_ready", 32'(m1_ready[1]), 32'd1);
        chk("nto_rd", m1_rd[1], 32'h5555_AAAA);
        tick();
        m1_req[1] = 0; mem_ready[1] = 0;
        tick();

        // Random traffic on both instances; masters follow the protocol.
        for (int cyc = 0; cyc < 500; cyc++) begin
            for (int d = 0; d < 2; d++) begin
                if (m0_req[d] && rdy0[d]) m0_req[d] = 0;
                if (m1_req[d] && rdy1[d]) m1_req[d] = 0;
                if (!m0_req[d] && $urandom_range(2) == 0) begin
                    m0_req[d] = 1; m0_we[d] = 1'($urandom_range(1)); m0_be[d] = 4'($urandom);
                    m0_addr[d] = $urandom; m0_wd[d] = $urandom;
                end
                if (!m1_req[d] && $urandom_range(2) == 0) begin
                    m1_req[d] = 1; m1_we[d] = 1'($urandom_range(1)); m1_be[d] = 4'($urandom);
                    m1_addr[d] = $urandom; m1_wd[d] = $urandom;
                end
                mem_ready[d] = ($urandom_range(2) == 0);
                mem_rd[d]    = $urandom;
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
